// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and width helpers for the instruction memory
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int off_w(input int iw);
        return $clog2(iw / 8);
    endfunction

endpackage

// File: rtl/imem_sp_ram.sv
// rtl/imem_sp_ram.sv - single-port DEPTH x IW RAM with registered read port
module imem_sp_ram #(
    parameter int IW     = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [IW-1:0]     wdata,
    output logic [IW-1:0]     rdata
);

    logic [IW-1:0] mem [DEPTH];

    // Storage stays unreset so it maps onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - streamed-load instruction memory with 1-cycle fault-checked fetch
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int          IW    = 32,
    parameter int          AW    = 64,
    parameter int          DEPTH = 1024,
    parameter logic [31:0] NOP   = RISCV_NOP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [IW-1:0]            load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     load_done,
    output logic                     load_overflow,
    output logic [$clog2(DEPTH):0]   words_loaded,
    input  logic                     fetch_req,
    input  logic [AW-1:0]            fetch_addr,
    output logic                     fetch_valid,
    output logic [IW-1:0]            fetch_instr,
    output logic                     fetch_fault
);

    localparam int IDXW = idx_w(DEPTH);
    localparam int OFFW = off_w(IW);
    localparam int WLW  = $clog2(DEPTH) + 1;

    localparam logic [AW-1:0]   OFF_MASK = AW'((64'd1 << OFFW) - 64'd1);
    localparam logic [IDXW-1:0] LAST_PTR = IDXW'(DEPTH - 1);
    localparam logic [WLW-1:0]  FULL_CNT = WLW'(DEPTH);

    state_t          state;
    logic [IDXW-1:0] wr_ptr;
    logic            fault_q;

    logic            fetch_acc;
    logic            wr_acc;
    logic [AW-1:0]   idx;
    logic            mis;
    logic            oor;
    logic [IDXW-1:0] ram_addr;
    logic [IW-1:0]   ram_rdata;

    assign fetch_acc = (state == RUN) && fetch_req;
    assign wr_acc    = (state == LOAD) && load_valid && !load_start;

    // Range check runs on the full-width index so huge PCs never alias low words.
    assign idx = fetch_addr >> OFFW;
    assign mis = (fetch_addr & OFF_MASK) != '0;
    assign oor = idx >= AW'(words_loaded);

    assign ram_addr = wr_acc ? wr_ptr : idx[IDXW-1:0];

    imem_sp_ram #(
        .IW     (IW),
        .DEPTH  (DEPTH),
        .ADDR_W (IDXW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fetch_acc || wr_acc),
        .we    (wr_acc),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_rdata)
    );

    // Both terms only update on an accepted fetch, so the output holds between responses.
    assign fetch_instr = fault_q ? IW'(NOP) : ram_rdata;
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            words_loaded  <= '0;
            load_ready    <= 1'b0;
            load_done     <= 1'b0;
            load_overflow <= 1'b0;
            fetch_valid   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            load_done   <= 1'b0;
            fetch_valid <= fetch_acc;
            if (fetch_acc) begin
                fault_q <= mis | oor;
            end

            if (load_start) begin
                state         <= LOAD;
                load_ready    <= 1'b1;
                wr_ptr        <= '0;
                words_loaded  <= '0;
                load_overflow <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (load_valid) begin
                            wr_ptr       <= wr_ptr + IDXW'(1);
                            words_loaded <= words_loaded + WLW'(1);
                            if (load_last || (wr_ptr == LAST_PTR)) begin
                                state      <= RUN;
                                load_ready <= 1'b0;
                                load_done  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (load_valid && (words_loaded == FULL_CNT)) begin
                            load_overflow <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - directed self-checking bench for instr_fetch_mem
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        load_start, load_valid, load_last;
    logic [31:0] load_data;
    logic        load_ready, load_done, load_overflow;
    logic [10:0] words_loaded;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        fetch_valid, fetch_fault;
    logic [31:0] fetch_instr;

    logic        s_load_start, s_load_valid, s_load_last;
    logic [31:0] s_load_data;
    logic        s_load_ready, s_load_done, s_load_overflow;
    logic [2:0]  s_words_loaded;
    logic        s_fetch_req;
    logic [63:0] s_fetch_addr;
    logic        s_fetch_valid, s_fetch_fault;
    logic [31:0] s_fetch_instr;

    int errors = 0;
    int checks = 0;

    logic [31:0] a_words [4] = '{32'hA000_0001, 32'hA111_0002, 32'hA222_0003, 32'hA333_0004};
    logic [31:0] b_words [4] = '{32'hB000_0010, 32'hB111_0020, 32'hB222_0030, 32'hB333_0040};
    logic [31:0] c_words [5] = '{32'hC000_0100, 32'hC111_0200, 32'hC222_0300, 32'hC333_0400, 32'hC444_0500};

    always #5 clk = ~clk;

    instr_fetch_mem u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .load_overflow (load_overflow),
        .words_loaded  (words_loaded),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_fault   (fetch_fault)
    );

    instr_fetch_mem #(.DEPTH(4)) u_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (s_load_start),
        .load_valid    (s_load_valid),
        .load_data     (s_load_data),
        .load_last     (s_load_last),
        .load_ready    (s_load_ready),
        .load_done     (s_load_done),
        .load_overflow (s_load_overflow),
        .words_loaded  (s_words_loaded),
        .fetch_req     (s_fetch_req),
        .fetch_addr    (s_fetch_addr),
        .fetch_valid   (s_fetch_valid),
        .fetch_instr   (s_fetch_instr),
        .fetch_fault   (s_fetch_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_req = 0; fetch_addr = '0;
        s_load_start = 0; s_load_valid = 0; s_load_last = 0; s_load_data = '0;
        s_fetch_req = 0; s_fetch_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({load_ready, load_done, load_overflow, fetch_valid, fetch_fault} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {load_ready, load_done, load_overflow, fetch_valid, fetch_fault});
        end
        checks++; if (words_loaded !== 11'd0) begin
            errors++; $display("FAIL reset_words: got %0d want 0", words_loaded);
        end
        checks++; if (fetch_instr !== 32'h0) begin
            errors++; $display("FAIL reset_instr: got %h want 00000000", fetch_instr);
        end
        rst_n = 1'b1;
        tick();
        fetch_req = 1'b1; fetch_addr = 64'd0;
        tick();
        tick();
        checks++; if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL idle_fetch_valid: got %b want 0", fetch_valid);
        end
        fetch_req = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] w [4], input bit req_during);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++; if (load_ready !== 1'b1 || words_loaded !== 11'd0) begin
            errors++; $display("FAIL load_enter: ready=%b words=%0d want ready=1 words=0", load_ready, words_loaded);
        end
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = w[i]; load_last = (i == 3);
            fetch_req = req_during && (i < 3); fetch_addr = 64'd0;
            tick();
            if (i < 3) begin
                checks++; if (load_done !== 1'b0 || words_loaded !== 11'(i + 1)) begin
                    errors++; $display("FAIL load_word%0d: done=%b words=%0d want done=0 words=%0d", i, load_done, words_loaded, i + 1);
                end
                if (req_during) begin
                    checks++; if (fetch_valid !== 1'b0) begin
                        errors++; $display("FAIL load_fetch_valid%0d: got %b want 0", i, fetch_valid);
                    end
                end
            end
        end
        load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
        checks++; if (load_done !== 1'b1 || load_ready !== 1'b0 || words_loaded !== 11'd4) begin
            errors++; $display("FAIL load_complete: done=%b ready=%b words=%0d want 1 0 4", load_done, load_ready, words_loaded);
        end
        tick();
        checks++; if (load_done !== 1'b0) begin
            errors++; $display("FAIL load_done_pulse: got %b want 0", load_done);
        end
    endtask

    task automatic test_load();
        load_words(a_words, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1; fetch_addr = 64'(i * 4);
            tick();
            checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b0 || fetch_instr !== a_words[i]) begin
                errors++; $display("FAIL b2b_fetch%0d: valid=%b fault=%b instr=%h want 1 0 %h", i, fetch_valid, fetch_fault, fetch_instr, a_words[i]);
            end
        end
        fetch_req = 1'b0;
        tick();
        checks++; if (fetch_valid !== 1'b0 || fetch_instr !== a_words[3]) begin
            errors++; $display("FAIL b2b_hold: valid=%b instr=%h want 0 %h", fetch_valid, fetch_instr, a_words[3]);
        end
    endtask

    task automatic test_fault();
        logic [63:0] addrs [4] = '{64'd6, 64'd16, 64'h0000_0100_0000_0000, 64'd1};
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1; fetch_addr = addrs[i];
            tick();
            checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b1 || fetch_instr !== 32'h0000_0013) begin
                errors++; $display("FAIL fault_addr_%h: valid=%b fault=%b instr=%h want 1 1 00000013", addrs[i], fetch_valid, fetch_fault, fetch_instr);
            end
        end
        fetch_addr = 64'd8;
        tick();
        checks++; if (fetch_fault !== 1'b0 || fetch_instr !== a_words[2]) begin
            errors++; $display("FAIL fault_recover: fault=%b instr=%h want 0 %h", fetch_fault, fetch_instr, a_words[2]);
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reload_inflight();
        fetch_req = 1'b1; fetch_addr = 64'd4; load_start = 1'b1;
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== a_words[1] || load_ready !== 1'b1 || words_loaded !== 11'd0) begin
            errors++; $display("FAIL inflight: valid=%b instr=%h ready=%b words=%0d want 1 %h 1 0", fetch_valid, fetch_instr, load_ready, words_loaded, a_words[1]);
        end
        tick();
        checks++; if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL inflight_after: valid=%b want 0", fetch_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = b_words[i]; load_last = 1'b0;
            tick();
        end
        load_valid = 1'b0;
        checks++; if (words_loaded !== 11'd2) begin
            errors++; $display("FAIL midload_words: got %0d want 2", words_loaded);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({load_ready, load_done, load_overflow, fetch_valid, fetch_fault} !== 5'b0 || words_loaded !== 11'd0 || fetch_instr !== 32'h0) begin
            errors++; $display("FAIL midload_reset: flags=%b words=%0d instr=%h want 00000 0 00000000",
                {load_ready, load_done, load_overflow, fetch_valid, fetch_fault}, words_loaded, fetch_instr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        load_words(b_words, 1'b0);
        fetch_req = 1'b1; fetch_addr = 64'd8;
        tick();
        fetch_req = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b0 || fetch_instr !== b_words[2]) begin
            errors++; $display("FAIL reload_fetch: valid=%b fault=%b instr=%h want 1 0 %h", fetch_valid, fetch_fault, fetch_instr, b_words[2]);
        end
    endtask

    task automatic test_overflow();
        s_load_start = 1'b1;
        tick();
        s_load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_load_valid = 1'b1; s_load_data = c_words[i]; s_load_last = 1'b0;
            tick();
            if (i == 3) begin
                checks++; if (s_load_done !== 1'b1 || s_words_loaded !== 3'd4 || s_load_ready !== 1'b0 || s_load_overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_autocomplete: done=%b words=%0d ready=%b ovf=%b want 1 4 0 0", s_load_done, s_words_loaded, s_load_ready, s_load_overflow);
                end
            end
        end
        s_load_valid = 1'b0;
        checks++; if (s_load_overflow !== 1'b1 || s_words_loaded !== 3'd4 || s_load_done !== 1'b0) begin
            errors++; $display("FAIL ovf_set: ovf=%b words=%0d done=%b want 1 4 0", s_load_overflow, s_words_loaded, s_load_done);
        end
        s_fetch_req = 1'b1; s_fetch_addr = 64'd12;
        tick();
        checks++; if (s_fetch_instr !== c_words[3] || s_fetch_fault !== 1'b0 || s_load_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_last_word: instr=%h fault=%b ovf=%b want %h 0 1", s_fetch_instr, s_fetch_fault, s_load_overflow, c_words[3]);
        end
        s_fetch_addr = 64'd16;
        tick();
        s_fetch_req = 1'b0;
        checks++; if (s_fetch_fault !== 1'b1 || s_fetch_instr !== 32'h0000_0013) begin
            errors++; $display("FAIL ovf_oor: fault=%b instr=%h want 1 00000013", s_fetch_fault, s_fetch_instr);
        end
        s_load_start = 1'b1;
        tick();
        s_load_start = 1'b0;
        checks++; if (s_load_overflow !== 1'b0 || s_words_loaded !== 3'd0) begin
            errors++; $display("FAIL ovf_clear: ovf=%b words=%0d want 0 0", s_load_overflow, s_words_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_fault();
        test_reload_inflight();
        test_reset_mid_load();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
